// File: rtl/chopper_sequencer_pkg.sv
// Shared microstepper definitions: phase encoding and default widths used by
// the chopper sequencer and its countdown-timer peer.
package chopper_sequencer_pkg;

  localparam int WIDTH_DEF     = 10;
  localparam int CNT_WIDTH_DEF = 16;

  localparam logic [1:0] PH_IDLE  = 2'd0;
  localparam logic [1:0] PH_BLANK = 2'd1;
  localparam logic [1:0] PH_ON    = 2'd2;
  localparam logic [1:0] PH_OFF   = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = PH_IDLE,
    BLANK = PH_BLANK,
    ON    = PH_ON,
    OFF   = PH_OFF
  } phase_e;

endpackage

// File: rtl/chopper_sequencer.sv
// Per-coil chopper: blanking / on / fixed-off-time sequencing driven by an
// external countdown timer. Define CHOPPER_FAST_DECAY_EN to split OFF into FAST+SLOW.
module chopper_sequencer
  import chopper_sequencer_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 enable,
  input  logic                 over_current,
  input  logic [WIDTH-1:0]     blank_time,
  input  logic [WIDTH-1:0]     off_time,
`ifdef CHOPPER_FAST_DECAY_EN
  input  logic [WIDTH-1:0]     fast_time,
`endif
  input  logic                 timer_done,
  output logic                 timer_start,
  output logic [WIDTH-1:0]     timer_load,
  output logic                 drive_on,
  output logic                 decay_fast,
  output logic [CNT_WIDTH-1:0] chop_count,
  output logic [1:0]           phase
);

  phase_e               state_r, state_s;
  logic                 start_r, start_s;
  logic [WIDTH-1:0]     load_r, load_s;
  logic                 drive_r, drive_s;
  logic [CNT_WIDTH-1:0] chop_r, chop_s;
  logic                 done_ok_s;
`ifdef CHOPPER_FAST_DECAY_EN
  logic                 fast_r, fast_s;
  logic                 decay_r, decay_s;
`endif

  // A done seen while our own load pulse is out belongs to the previous load.
  assign done_ok_s = timer_done & ~start_r;

  // Next-state and next-output decode; enable=0 overrides every other input.
  always_comb begin
    state_s = state_r;
    start_s = 1'b0;
    load_s  = load_r;
    drive_s = drive_r;
    chop_s  = chop_r;
`ifdef CHOPPER_FAST_DECAY_EN
    fast_s  = fast_r;
    decay_s = decay_r;
`endif
    if (!enable) begin
      state_s = IDLE;
      drive_s = 1'b0;
`ifdef CHOPPER_FAST_DECAY_EN
      fast_s  = 1'b0;
      decay_s = 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          state_s = BLANK;
          drive_s = 1'b1;
          start_s = 1'b1;
          load_s  = blank_time;
        end
        BLANK: begin
          drive_s = 1'b1;
          if (done_ok_s) begin
            state_s = ON;
          end else begin
            state_s = BLANK;
          end
        end
        ON: begin
          if (over_current) begin
            state_s = OFF;
            drive_s = 1'b0;
            start_s = 1'b1;
            chop_s  = chop_r + CNT_WIDTH'(1);
`ifdef CHOPPER_FAST_DECAY_EN
            fast_s  = 1'b1;
            decay_s = 1'b1;
            load_s  = fast_time;
`else
            load_s  = off_time;
`endif
          end else begin
            drive_s = 1'b1;
          end
        end
        OFF: begin
          if (!done_ok_s) begin
            drive_s = 1'b0;
`ifdef CHOPPER_FAST_DECAY_EN
          end else if (fast_r) begin
            fast_s  = 1'b0;
            decay_s = 1'b0;
            start_s = 1'b1;
            load_s  = off_time;
`endif
          end else begin
            state_s = BLANK;
            drive_s = 1'b1;
            start_s = 1'b1;
            load_s  = blank_time;
          end
        end
        default: begin
          state_s = IDLE;
          drive_s = 1'b0;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= IDLE;
      start_r <= 1'b0;
      load_r  <= '0;
      drive_r <= 1'b0;
      chop_r  <= '0;
`ifdef CHOPPER_FAST_DECAY_EN
      fast_r  <= 1'b0;
      decay_r <= 1'b0;
`endif
    end else begin
      state_r <= state_s;
      start_r <= start_s;
      load_r  <= load_s;
      drive_r <= drive_s;
      chop_r  <= chop_s;
`ifdef CHOPPER_FAST_DECAY_EN
      fast_r  <= fast_s;
      decay_r <= decay_s;
`endif
    end
  end

  assign timer_start = start_r;
  assign timer_load  = load_r;
  assign drive_on    = drive_r;
  assign chop_count  = chop_r;
  assign phase       = state_r;
`ifdef CHOPPER_FAST_DECAY_EN
  assign decay_fast  = decay_r;
`else
  assign decay_fast  = 1'b0;
`endif

endmodule

// File: tb/tb_chopper_sequencer.sv
// Directed + randomized bench for chopper_sequencer paired with a behavioural
// countdown timer (load N -> done N+1 cycles after the load pulse).
module tb_chopper_sequencer;

  localparam int W  = 10;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          resetn, enable, over_current;
  logic [W-1:0]  blank_time, off_time, timer_load;
  logic          timer_done = 1'b0;
  logic          timer_start, drive_on, decay_fast;
  logic [CW-1:0] chop_count;
  logic [1:0]    phase;
`ifdef CHOPPER_FAST_DECAY_EN
  logic [W-1:0]  fast_time;
`endif

  int checks = 0;
  int errors = 0;
  int exp_chop = 0;
  int cur_blank;

  always #5 clk = ~clk;

  chopper_sequencer #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clk(clk), .resetn(resetn), .enable(enable), .over_current(over_current),
    .blank_time(blank_time), .off_time(off_time),
`ifdef CHOPPER_FAST_DECAY_EN
    .fast_time(fast_time),
`endif
    .timer_done(timer_done), .timer_start(timer_start), .timer_load(timer_load),
    .drive_on(drive_on), .decay_fast(decay_fast), .chop_count(chop_count), .phase(phase)
  );

  // Countdown timer peer: a new load restarts it; done pulses one cycle.
  logic [W-1:0] rem = '0;
  logic         armed = 1'b0;
  always @(posedge clk) begin
    if (timer_start) begin
      rem        <= timer_load;
      armed      <= (timer_load != '0);
      timer_done <= (timer_load == '0);
    end else if (armed) begin
      rem        <= rem - 1'b1;
      timer_done <= (rem == 1);
      armed      <= (rem != 1);
    end else begin
      timer_done <= 1'b0;
    end
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_st(string tag, int ph, int drv, int st, int dec);
    chk({tag, "_phase"}, 32'(phase), ph);
    chk({tag, "_drive"}, 32'(drive_on), drv);
    chk({tag, "_start"}, 32'(timer_start), st);
    chk({tag, "_decay"}, 32'(decay_fast), dec);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic oc_val(int mode);
    if (mode == 2) return logic'($urandom_range(0, 1));
    return (mode == 1);
  endfunction

  // Starting in the BLANK load-pulse cycle, run one full chop and end in the next one.
  task automatic run_chop(int blank, int off, int on_wait, int mode, int next_blank);
    off_time = W'(off);
    for (int k = 0; k <= blank; k++) begin
      over_current = oc_val(mode); tick(); chk_st("blank", 1, 1, 0, 0);
    end
    over_current = oc_val(mode); tick(); chk_st("on_entry", 2, 1, 0, 0);
    blank_time = W'(next_blank);
    for (int j = 0; j < on_wait; j++) begin
      over_current = 1'b0; tick(); chk_st("on_wait", 2, 1, 0, 0);
    end
    over_current = 1'b1; tick();
    exp_chop = (exp_chop + 1) % (1 << CW);
`ifdef CHOPPER_FAST_DECAY_EN
    chk_st("fast_entry", 3, 0, 1, 1);
    chk("fast_load", 32'(timer_load), 32'(fast_time));
    for (int k = 0; k <= int'(fast_time); k++) begin
      over_current = oc_val(2); tick(); chk_st("fast", 3, 0, 0, 1);
    end
    over_current = oc_val(2); tick(); chk_st("slow_entry", 3, 0, 1, 0);
    chk("slow_load", 32'(timer_load), off);
`else
    chk_st("off_entry", 3, 0, 1, 0);
    chk("off_load", 32'(timer_load), off);
`endif
    chk("chop", 32'(chop_count), exp_chop);
    for (int k = 0; k <= off; k++) begin
      over_current = oc_val(2); tick(); chk_st("off", 3, 0, 0, 0);
    end
    over_current = oc_val(2); tick(); chk_st("reblank", 1, 1, 1, 0);
    chk("reblank_load", 32'(timer_load), next_blank);
  endtask

  initial begin
    resetn = 1'b1; enable = 1'b0; over_current = 1'b0;
    blank_time = '0; off_time = '0;
`ifdef CHOPPER_FAST_DECAY_EN
    fast_time = W'(4);
`endif
    #1 resetn = 1'b0;
    #2 chk_st("reset", 0, 0, 0, 0);
    chk("reset_load", 32'(timer_load), 0);
    chk("reset_chop", 32'(chop_count), 0);
    tick(); resetn = 1'b1;
    for (int k = 0; k < 3; k++) begin tick(); chk_st("idle_hold", 0, 0, 0, 0); end

    // Asynchronous reset asserted mid-cycle while running
    enable = 1'b1; blank_time = W'(7);
    tick(); chk_st("pre_rst", 1, 1, 1, 0);
    tick();
    #2 resetn = 1'b0;
    #1 chk_st("async_rst", 0, 0, 0, 0);
    chk("async_rst_load", 32'(timer_load), 0);
    enable = 1'b0;
    tick(); resetn = 1'b1;
    tick(); chk_st("rst_release", 0, 0, 0, 0);

    // Basic cycle, then blanking with over_current held high
    blank_time = W'(5); enable = 1'b1;
    tick(); chk_st("start", 1, 1, 1, 0);
    chk("start_load", 32'(timer_load), 5);
`ifdef CHOPPER_FAST_DECAY_EN
    fast_time = W'(4);
    run_chop(5, 10, 3, 0, 8);
`else
    run_chop(5, 20, 3, 0, 8);
`endif
    run_chop(8, 6, 0, 1, 3);
    cur_blank = 3;

    // Randomized chops (also wraps the chop counter)
    for (int i = 0; i < 20; i++) begin
      int nb;
      nb = $urandom_range(0, 10);
`ifdef CHOPPER_FAST_DECAY_EN
      fast_time = W'($urandom_range(0, 6));
`endif
      run_chop(cur_blank, $urandom_range(0, 25), $urandom_range(0, 4), 2, nb);
      cur_blank = nb;
    end

    // Disable mid-OFF with a long off time
    off_time = W'(100);
    for (int k = 0; k <= cur_blank; k++) begin over_current = 1'b0; tick(); end
    tick(); chk("dis_on", 32'(phase), 2);
    over_current = 1'b1; tick();
    exp_chop = (exp_chop + 1) % (1 << CW);
    chk("dis_off_entry", 32'(phase), 3);
    over_current = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    chk("dis_mid_off", 32'(phase), 3);
    enable = 1'b0; over_current = 1'b1;
    tick(); chk_st("dis_idle", 0, 0, 0, 0);
    for (int k = 0; k < 110; k++) begin
      tick();
      if (timer_start !== 1'b0 || phase !== 2'd0) chk("dis_quiet", {timer_start, phase}, 0);
    end
    chk_st("dis_after", 0, 0, 0, 0);
    chk("dis_chop", 32'(chop_count), exp_chop);

    // Zero blank load, enable priority over over_current and over timer_done
    over_current = 1'b0; blank_time = '0; enable = 1'b1;
    tick(); chk_st("z_start", 1, 1, 1, 0);
    chk("z_load", 32'(timer_load), 0);
    tick(); chk_st("z_done", 1, 1, 0, 0);
    tick(); chk_st("z_on", 2, 1, 0, 0);
    enable = 1'b0; over_current = 1'b1;
    tick(); chk_st("pri_oc", 0, 0, 0, 0);
    chk("pri_oc_chop", 32'(chop_count), exp_chop);
    over_current = 1'b0; enable = 1'b1;
    tick(); chk_st("z2_start", 1, 1, 1, 0);
    tick(); chk("z2_done_seen", 32'(timer_done), 1);
    enable = 1'b0;
    tick(); chk_st("pri_done", 0, 0, 0, 0);
    tick(); chk_st("pri_done_hold", 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/chopper_sequencer.md
Name: chopper_sequencer

Overview:
- Initiator side of the microstepper countdown-timer interface.
- Drives the timer's load pulse and load value, and consumes its single-cycle done event.
- Sequences one H-bridge coil through blanking, on, and fixed-off-time decay phases, in response to the current comparator.
- One instance per coil; sits between the current comparator/DAC path and the bridge output mux.

Parameters:
- WIDTH, 10, width of timer load values (matches countdown timer WIDTH).
- CNT_WIDTH, 16, width of the chop event counter.

Ports:
- clk  input  1  system clock.
- resetn  input  1  reset; asynchronous, active-low (already decided).
- enable  input  1  coil enable; level-sensitive.
- over_current  input  1  comparator output, already synchronised to clk; 1 = coil current above target.
- blank_time  input  WIDTH  blanking load value, sampled on the timer_start cycle.
- off_time  input  WIDTH  off-time load value, sampled on the timer_start cycle.
- timer_done  input  1  single-cycle done event from the countdown timer.
- timer_start  output  1  one-cycle load pulse to the timer (its start_enable).
- timer_load  output  WIDTH  value loaded with timer_start (its start_time).
- drive_on  output  1  1 = bridge driving the coil.
- decay_fast  output  1  1 = fast-decay bridge configuration while off.
- chop_count  output  CNT_WIDTH  count of over-current chop events; wraps.
- phase  output  2  current state encoding, for debug.

Behaviour:
- All outputs are registered.
- Reset (resetn=0, asynchronous): state IDLE, timer_start=0, timer_load=0, drive_on=0, decay_fast=0, chop_count=0.
- States and encoding: IDLE=0, BLANK=1, ON=2, OFF=3.
- IDLE:
  - drive_on=0.
  - enable=1 sampled at edge t → at t+1: state BLANK, drive_on=1, timer_start=1, timer_load=blank_time.
- BLANK:
  - drive_on=1; over_current ignored.
  - timer_done=1 → next cycle ON.
- ON:
  - drive_on=1.
  - over_current=1 → next cycle: OFF, drive_on=0, timer_start=1, timer_load=off_time, chop_count+1.
- OFF:
  - drive_on=0.
  - timer_done=1 → next cycle: BLANK, drive_on=1, timer_start=1, timer_load=blank_time.
- timer_start handling:
  - Pulse is exactly one cycle; it deasserts the following cycle.
  - timer_load holds its last value afterwards.
- timer_done handling:
  - Ignored in IDLE and ON.
  - Ignored in the cycle timer_start=1, which blocks stale done from a previous load.
- A load value of 0 is legal; the controller simply waits for done.
- Timer latency: a load of N produces done N+1 cycles after the timer_start cycle. The controller never counts itself.
- enable=0 in any state → next cycle IDLE, drive_on=0, decay_fast=0, no timer_start; the timer is left running and its done is ignored.
- enable=0 has priority over over_current and timer_done in the same cycle.
- Simultaneous timer_done and over_current in BLANK: done wins → ON; over_current is re-evaluated in ON on the next cycle.
- chop_count wraps from 2^CNT_WIDTH-1 to 0; it is not cleared by enable=0.
- Reset mid-operation: immediate return to reset values regardless of state.

Optional Feature:
- Macro: CHOPPER_FAST_DECAY_EN.
- Defined:
  - Adds input port fast_time [WIDTH].
  - On over_current in ON, the OFF phase splits into two sub-phases:
    - FAST: decay_fast=1, timer loaded with fast_time.
    - On done: SLOW, decay_fast=0, timer re-started with off_time in the next cycle.
    - Done in SLOW → BLANK.
  - fast_time=0 still runs a FAST sub-phase (N+1 cycles).
  - phase reports 3 for both sub-phases; an internal bit distinguishes them.
- Undefined: no fast_time port; decay_fast is constant 0.

Decomposition:
- Shared microstepper package:
  - state encoding localparams (IDLE/BLANK/ON/OFF);
  - default WIDTH=10;
  - CNT_WIDTH default.
- No sub-module: the FSM and counter are flat.
- The countdown timer stays a separate peer instance, wired by the parent.

Test Plan:
All scenarios pair the block with the team countdown timer (WIDTH=10).
1. Reset: resetn=0 asserted mid-cycle → all outputs 0 immediately (asynchronously); release with enable=0 → outputs remain 0.
2. Basic cycle: blank_time=5, off_time=20, enable=1, over_current pulsed 3 cycles after ON entry →
   - timer_start pulse carries timer_load=5;
   - ON entered 7 cycles after that pulse (done 6 cycles after it, ON the next cycle);
   - drive_on falls with timer_start/timer_load=20;
   - BLANK re-entered 22 cycles later;
   - chop_count=1.
3. Blanking: over_current held 1 throughout BLANK with blank_time=8 → drive_on stays 1 until ON; OFF is entered on the first ON cycle's sample.
4. Disable mid-OFF: enable=0 during OFF with off_time=100 → IDLE next cycle; no further timer_start; late timer_done ignored; chop_count retained.
5. Priority and zero load: blank_time=0 → done after 1 cycle, ON reached; enable=0 coincident with timer_done → IDLE, not ON.
6. With CHOPPER_FAST_DECAY_EN, fast_time=4, off_time=10 →
   - decay_fast=1 for the FAST span;
   - second timer_start with load 10;
   - decay_fast=0 during SLOW;
   - chop_count increments once per over_current event.
